// File: rtl/dispatcher_pkg.sv
// Shared types for the dispatch stage: instruction record, station enumeration and the
// instruction-type to reservation-station mapping.
package dispatcher_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_ALU,
    ST_BRANCH,
    ST_LSU,
    ST_MULDIV
  } station_e;

  typedef enum logic [2:0] {
    IT_ALU     = 3'd0,
    IT_BRANCH  = 3'd1,
    IT_LOAD    = 3'd2,
    IT_STORE   = 3'd3,
    IT_MUL     = 3'd4,
    IT_DIV     = 3'd5,
    IT_UNKNOWN = 3'd7
  } instr_type_e;

  typedef struct packed {
    logic [5:0] rd;
    logic [5:0] rs1;
    logic [5:0] rs2;
  } regs_t;

  typedef struct packed {
    logic tag;
    logic pred_taken;
  } flags_t;

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] immediate;
    logic [7:0]      instr_name;
    instr_type_e     instr_type;
    regs_t           regs;
    flags_t          flags;
  } instr_info_t;

  // Unknown and unencoded types fall back to the ALU station.
  function automatic station_e station_of(instr_type_e t);
    station_e st;
    case (t)
      IT_BRANCH:        st = ST_BRANCH;
      IT_LOAD,
      IT_STORE:         st = ST_LSU;
      IT_MUL,
      IT_DIV:           st = ST_MULDIV;
      default:          st = ST_ALU;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/dispatch_queue.sv
// In-order circular buffer with 2-wide write and 2-wide read, flush, and truncation of the
// tagged (speculative) tail.
module dispatch_queue
  import dispatcher_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              clear_tagged_i,
  input  logic              commit_tag_i,
  input  logic [1:0]        wr_req_i,
  input  instr_info_t [1:0] wr_data_i,
  input  logic [1:0]        rd_cnt_i,
  output instr_info_t [1:0] rd_data_o,
  output logic [PtrW:0]     count_o,
  output logic [PtrW:0]     count_next_o,
  output logic              overflow_o
);

  instr_info_t           mem_q [Depth];
  instr_info_t           mem_d [Depth];
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d, wtail;
  logic [PtrW:0]         count_q, count_d, keep_len, base, free;
  logic [1:0]            wr_acc;
  logic                  found;

  always_comb begin
    // Distance from head to the first tagged entry; younger entries are all tagged.
    keep_len = count_q;
    found    = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (!found && ((PtrW+1)'(i) < count_q) && mem_q[head_q + PtrW'(i)].flags.tag) begin
        keep_len = (PtrW+1)'(i);
        found    = 1'b1;
      end
    end

    base       = (clear_tagged_i ? keep_len : count_q) - {{(PtrW-1){1'b0}}, rd_cnt_i};
    free       = (PtrW+1)'(Depth) - base;
    overflow_o = 1'b0;
    wr_acc     = wr_req_i;
    if ({{(PtrW-1){1'b0}}, wr_req_i} > free) begin
      wr_acc     = free[1:0];
      overflow_o = 1'b1;
    end
    wtail = clear_tagged_i ? head_q + keep_len[PtrW-1:0] : tail_q;

    mem_d = mem_q;
    if (commit_tag_i && !clear_tagged_i) begin
      for (int unsigned i = 0; i < Depth; i++) mem_d[i].flags.tag = 1'b0;
    end
    if (wr_acc != 2'd0) mem_d[wtail] = wr_data_i[0];
    if (wr_acc == 2'd2) mem_d[wtail + PtrW'(1)] = wr_data_i[1];

    head_d  = head_q + {{(PtrW-2){1'b0}}, rd_cnt_i};
    tail_d  = wtail + {{(PtrW-2){1'b0}}, wr_acc};
    count_d = base + {{(PtrW-1){1'b0}}, wr_acc};

    if (flush_i) begin
      mem_d      = mem_q;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rd_data_o[0] = mem_q[head_q];
  assign rd_data_o[1] = mem_q[head_q + PtrW'(1)];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/dispatcher.sv
// Dispatch stage: input packing, in-order dual issue to reservation stations and ROB, and
// flush / speculative-clear priority. Storage lives in dispatch_queue.
module dispatcher
  import dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NUM_RS = 4,
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              clear_tagged,
  input  logic              commit_tag,
  input  logic [1:0]        in_valid,
  input  instr_info_t [1:0] in_instr,
  output logic              stop_out,
  input  logic [1:0]        rob_free,
  input  logic [NUM_RS-1:0] rs_ready,
  output logic [1:0]        out_valid,
  output instr_info_t [1:0] out_instr,
  output station_e [1:0]    out_station,
  output logic              overflow
);

  logic [1:0]        wr_v, wr_req, rd_cnt;
  instr_info_t [1:0] wr_data;
  logic [CntW-1:0]   count, count_next;
  logic              wr_drop;
  logic              stop_q, stop_d, overflow_q, overflow_d;

  always_comb begin
    wr_v = in_valid;
    if (clear_tagged) wr_v = wr_v & ~{in_instr[1].flags.tag, in_instr[0].flags.tag};
    if (flush)        wr_v = 2'b00;
    // Pack so that a lone slot1 lands in queue slot 0.
    wr_data[0] = wr_v[0] ? in_instr[0] : in_instr[1];
    wr_data[1] = in_instr[1];
    if (commit_tag && !clear_tagged) begin
      wr_data[0].flags.tag = 1'b0;
      wr_data[1].flags.tag = 1'b0;
    end
    wr_req = {1'b0, wr_v[0]} + {1'b0, wr_v[1]};
  end

  always_comb begin
    out_station[0] = station_of(out_instr[0].instr_type);
    out_station[1] = station_of(out_instr[1].instr_type);
    out_valid[0]   = !flush && (count >= CntW'(1)) && rs_ready[out_station[0]]
                     && (rob_free != 2'd0)
                     && !(clear_tagged && out_instr[0].flags.tag);
    out_valid[1]   = out_valid[0] && (count >= CntW'(2))
                     && (out_station[1] != out_station[0]) && rs_ready[out_station[1]]
                     && (rob_free >= 2'd2)
                     && !(clear_tagged && out_instr[1].flags.tag);
    rd_cnt         = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
    stop_d         = count_next > CntW'(DEPTH - 2);
    overflow_d     = overflow_q | wr_drop;
  end

  dispatch_queue #(
    .Depth (DEPTH)
  ) u_queue (
    .clk_i          (clock),
    .rst_ni         (reset),
    .flush_i        (flush),
    .clear_tagged_i (clear_tagged),
    .commit_tag_i   (commit_tag),
    .wr_req_i       (wr_req),
    .wr_data_i      (wr_data),
    .rd_cnt_i       (rd_cnt),
    .rd_data_o      (out_instr),
    .count_o        (count),
    .count_next_o   (count_next),
    .overflow_o     (wr_drop)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      stop_q     <= stop_d;
      overflow_q <= overflow_d;
    end
  end

  assign stop_out = stop_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_dispatcher.sv
// Directed vector bench for dispatcher: per-cycle table plus a mid-cycle reset sequence.
module tb_dispatcher;
  import dispatcher_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush, clear_tagged, commit_tag;
  logic [1:0]        in_valid;
  instr_info_t [1:0] in_instr;
  logic              stop_out;
  logic [1:0]        rob_free;
  logic [3:0]        rs_ready;
  logic [1:0]        out_valid;
  instr_info_t [1:0] out_instr;
  station_e [1:0]    out_station;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  dispatcher #(
    .DEPTH  (8),
    .NUM_RS (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .clear_tagged (clear_tagged),
    .commit_tag   (commit_tag),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .stop_out     (stop_out),
    .rob_free     (rob_free),
    .rs_ready     (rs_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_station  (out_station),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fl, ct, cm;
    logic [1:0]  iv;
    instr_type_e t0, t1;
    logic        g0, g1;
    logic [7:0]  a0, a1;
    logic [3:0]  rs;
    logic [1:0]  rf;
    logic [1:0]  e_ov;
    logic [7:0]  e_a;
    logic [3:0]  e_cnt;
    logic        e_stop, e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic fl, logic ct, logic cm, logic [1:0] iv, instr_type_e t0,
                               instr_type_e t1, logic g0, logic g1, logic [7:0] a0,
                               logic [7:0] a1, logic [3:0] rs, logic [1:0] rf, logic [1:0] e_ov,
                               logic [7:0] e_a, logic [3:0] e_cnt, logic e_stop, logic e_ovf);
    vec_t v;
    v.fl = fl; v.ct = ct; v.cm = cm; v.iv = iv; v.t0 = t0; v.t1 = t1; v.g0 = g0; v.g1 = g1;
    v.a0 = a0; v.a1 = a1; v.rs = rs; v.rf = rf; v.e_ov = e_ov; v.e_a = e_a; v.e_cnt = e_cnt;
    v.e_stop = e_stop; v.e_ovf = e_ovf;
    return v;
  endfunction

  function automatic instr_info_t mki(instr_type_e t, logic tag, logic [7:0] a);
    instr_info_t r;
    r            = '0;
    r.instr_type = t;
    r.flags.tag  = tag;
    r.address    = {24'h0, a};
    r.immediate  = {24'h0, ~a};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    flush        = v.fl;
    clear_tagged = v.ct;
    commit_tag   = v.cm;
    in_valid     = v.iv;
    in_instr[0]  = mki(v.t0, v.g0, v.a0);
    in_instr[1]  = mki(v.t1, v.g1, v.a1);
    rs_ready     = v.rs;
    rob_free     = v.rf;
  endtask

  initial begin
    reset = 1'b0;
    drive(mkv(0,0,0,2'b00,IT_ALU,IT_ALU,0,0,0,0,4'b0000,2'd0,0,0,0,0,0));
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_stop", 32'(stop_out), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    //            fl ct cm iv     t0         t1         g0 g1 a0 a1 rs       rf  e_ov  e_a cnt st ovf
    // Dual issue to distinct stations
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_MUL,    0,0,10,11,4'b1111,2'd2,2'b00,0, 2,0,0));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1111,2'd2,2'b11,10,0,0,0));
    // Same station: one per cycle
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_ALU,    0,0,20,21,4'b1111,2'd2,2'b00,0, 2,0,0));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1111,2'd2,2'b01,20,1,0,0));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1111,2'd2,2'b01,21,0,0,0));
    // rob_free=1 limits to one; rs_ready gating of BRANCH head
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_BRANCH, 0,0,30,31,4'b1111,2'd1,2'b00,0, 2,0,0));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1111,2'd1,2'b01,30,1,0,0));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b0000,2'd2,2'b00,0, 1,0,0));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1101,2'd2,2'b00,0, 1,0,0));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b0010,2'd2,2'b01,31,0,0,0));
    // Fill to 8, stop_out at 7, overflow on 9th
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_ALU,    0,0,40,41,4'b0000,2'd2,2'b00,0, 2,0,0));
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_ALU,    0,0,42,43,4'b0000,2'd2,2'b00,0, 4,0,0));
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_ALU,    0,0,44,45,4'b0000,2'd2,2'b00,0, 6,0,0));
    vecs.push_back(mkv(0,0,0,2'b10,IT_ALU,    IT_ALU,    0,0, 0,47,4'b0000,2'd2,2'b00,0, 7,1,0));
    vecs.push_back(mkv(0,0,0,2'b01,IT_ALU,    IT_ALU,    0,0,48, 0,4'b0000,2'd2,2'b00,0, 8,1,0));
    vecs.push_back(mkv(0,0,0,2'b01,IT_ALU,    IT_ALU,    0,0,49, 0,4'b0000,2'd2,2'b00,0, 8,1,1));
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_ALU,    0,0,50,51,4'b0001,2'd2,2'b01,40,8,1,1));
    // Flush beats a ready head and drops inputs
    vecs.push_back(mkv(1,0,0,2'b11,IT_ALU,    IT_MUL,    0,0,60,61,4'b1111,2'd2,2'b00,0, 0,0,1));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1111,2'd2,2'b00,0, 0,0,1));
    // 3 untagged + 2 tagged, clear_tagged wins over commit_tag
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_ALU,    0,0,50,51,4'b0000,2'd2,2'b00,0, 2,0,1));
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_ALU,    0,1,52,53,4'b0000,2'd2,2'b00,0, 4,0,1));
    vecs.push_back(mkv(0,0,0,2'b01,IT_ALU,    IT_ALU,    1,0,54, 0,4'b0000,2'd2,2'b00,0, 5,0,1));
    vecs.push_back(mkv(0,1,1,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b0000,2'd2,2'b00,0, 3,0,1));
    vecs.push_back(mkv(0,0,0,2'b01,IT_MUL,    IT_ALU,    0,0,55, 0,4'b0000,2'd2,2'b00,0, 4,0,1));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1111,2'd2,2'b01,50,3,0,1));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1111,2'd2,2'b01,51,2,0,1));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1111,2'd2,2'b11,52,0,0,1));
    // commit_tag alone protects entries from a later clear_tagged
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_MUL,    1,1,60,61,4'b0000,2'd2,2'b00,0, 2,0,1));
    vecs.push_back(mkv(0,0,1,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b0000,2'd2,2'b00,0, 2,0,1));
    vecs.push_back(mkv(0,1,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b0000,2'd2,2'b00,0, 2,0,1));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1111,2'd2,2'b11,60,0,0,1));
    // clear_tagged: untagged head still issues, tagged input dropped
    vecs.push_back(mkv(0,0,0,2'b11,IT_ALU,    IT_MUL,    0,1,70,71,4'b0000,2'd2,2'b00,0, 2,0,1));
    vecs.push_back(mkv(0,1,0,2'b01,IT_ALU,    IT_ALU,    1,0,72, 0,4'b1111,2'd2,2'b01,70,0,0,1));
    // UNKNOWN maps to ALU station
    vecs.push_back(mkv(0,0,0,2'b11,IT_UNKNOWN,IT_DIV,    0,0,80,81,4'b0000,2'd2,2'b00,0, 2,0,1));
    vecs.push_back(mkv(0,0,0,2'b00,IT_ALU,    IT_ALU,    0,0, 0, 0,4'b1001,2'd2,2'b11,80,0,0,1));

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov[0])
        chk($sformatf("v%0d_head_addr", i), out_instr[0].address, 32'(vecs[i].e_a));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_count", i), 32'(dut.u_queue.count_o), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_stop_out", i), 32'(stop_out), 32'(vecs[i].e_stop));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end

    // Fill to 7 entries, then assert reset in the middle of a cycle
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive(mkv(0,0,0,(k == 3) ? 2'b01 : 2'b11,IT_ALU,IT_BRANCH,0,0,8'(90+2*k),8'(91+2*k),
                4'b0000,2'd2,0,0,0,0,0));
    end
    @(negedge clock);
    drive(mkv(0,0,0,2'b00,IT_ALU,IT_ALU,0,0,0,0,4'b1111,2'd2,0,0,0,0,0));
    #1;
    chk("seq_stop_before_reset", 32'(stop_out), 32'd1);
    chk("seq_dual_issue", 32'(out_valid), 32'd3);
    chk("seq_station1", 32'(out_station[1]), 32'(ST_BRANCH));
    rob_free = 2'd1;
    #1;
    chk("seq_rob1_issue", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("seq_async_out_valid", 32'(out_valid), 32'd0);
    chk("seq_async_stop", 32'(stop_out), 32'd0);
    chk("seq_async_overflow", 32'(overflow), 32'd0);
    chk("seq_async_count", 32'(dut.u_queue.count_o), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("seq_after_reset_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
